iot_frame_feeder: RTL and testbench
===================================

// Module: iot_frame_feeder
// PURPOSE
//  Transmit side of the IoT byte-stream protocol. Accepts one 128-bit frame plus function code from a host,
//  serializes it MSB-byte-first onto iot_in/in_en (honouring busy), then waits for the filter's valid/iot_out,
//  captures the result and returns it to the host through a valid/ready handshake. Sits between host and filter core.
// PARAMETERS
//  FRAME_BYTES   16    bytes per frame (frame width = 8*FRAME_BYTES)
//  TIMEOUT_CYC   1023  max WAIT cycles before timeout (used only with IOT_FEED_TIMEOUT_EN)
// PORTS
//  clk        in   1    single clock, rising edge
//  rst        in   1    synchronous, active-high reset
//  s_valid    in   1    host frame valid
//  s_ready    out  1    feeder can accept a frame
//  s_data     in   128  frame; byte 15 = s_data[127:120] sent first
//  s_fn       in   3    function code for this frame
//  busy       in   1    filter busy; no byte may be sent while high
//  in_en      out  1    byte strobe to filter
//  iot_in     out  8    byte to filter
//  fn_sel     out  3    function code to filter
//  valid      in   1    filter result strobe (1 cycle)
//  iot_out    in   128  filter result
//  r_valid    out  1    result available to host
//  r_ready    in   1    host accepts result
//  r_data     out  128  captured result
//  r_fn       out  3    function code the result belongs to
//  err_timeout out 1    result is a timeout, not real data
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, byte_cnt=0, shift reg=0, fn reg=0, r_data=0, r_fn=0, r_valid=0,
//    err_timeout=0. Hence s_ready=1, in_en=0, iot_in=0, fn_sel=0 after reset. Reset mid-frame aborts silently.
//  - States: IDLE -> SEND -> WAIT -> HOLD -> IDLE.
//  - IDLE: s_ready=1. On s_valid&s_ready: latch s_data to shift reg, s_fn to fn reg, byte_cnt=0, -> SEND.
//    s_ready=0 in all other states; s_valid there is ignored (host holds it).
//  - SEND: in_en = !busy (combinational from registered state + busy); iot_in = shift[127:120].
//    On each in_en cycle: shift <<= 8, byte_cnt++. busy=1 stalls: byte and count held, in_en=0.
//    The cycle the 16th byte is sent (byte_cnt==FRAME_BYTES-1 & in_en) -> WAIT. Exactly 16 strobes per frame.
//  - iot_in = 0 whenever in_en=0. fn_sel = fn reg, held stable from SEND until leaving WAIT.
//  - WAIT: on valid=1: r_data<=iot_out, r_fn<=fn reg, r_valid<=1, err_timeout<=0, -> HOLD.
//    valid arriving in IDLE/SEND/HOLD is ignored (no capture, no state change).
//  - HOLD: r_valid=1, r_data/r_fn stable. On r_ready: r_valid<=0, -> IDLE. Next frame accepted 1 cycle later.
//  - Latency: accept -> first in_en = 1 cycle (busy low); valid -> r_valid = 1 cycle.
//  - Simultaneous: busy rising in the same cycle as a would-be strobe blocks that strobe (busy wins).
// CONFIGURATION
//  IOT_FEED_TIMEOUT_EN defined: WAIT runs a counter cleared on entry; if it reaches TIMEOUT_CYC with no valid,
//   -> HOLD with r_data=0, r_fn=fn reg, r_valid=1, err_timeout=1 (held until r_ready). valid on the same cycle
//   as terminal count wins (real capture, err_timeout=0).
//  Not defined: no counter; WAIT lasts indefinitely; err_timeout tied 0.
// TESTING
//  1. Reset, s_fn=3'd3, s_data=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, busy=0 -> iot_in 01,23,..,10 on
//     16 consecutive in_en cycles; valid with iot_out=X -> r_valid=1, r_data=X, r_fn=3.
//  2. busy=1 for 3 cycles after 5th byte -> in_en=0 for those cycles, byte 6 (8'hAB) sent after, 16 strobes total.
//  3. valid pulsed during SEND and during IDLE -> no capture, r_valid stays 0; frame completes normally.
//  4. r_ready held 0 for 10 cycles in HOLD -> r_data/r_fn stable, s_ready=0; r_ready=1 -> IDLE, s_ready=1 next.
//  5. rst asserted after 7th byte -> next cycle in_en=0, s_ready=1, r_valid=0; new frame restarts at byte 15.
//  6. IOT_FEED_TIMEOUT_EN, TIMEOUT_CYC=8, no valid -> r_valid=1, err_timeout=1, r_data=0 after 8 WAIT cycles.

Source files
------------

// File: rtl/iot_frame_feeder.sv
// iot_frame_feeder: transmit side of the IoT byte-stream protocol.
// Takes one frame plus function code from the host and sends it to the filter MSB byte first,
// one byte per cycle whenever the filter is not busy. It then waits for the filter's result
// strobe and hands the captured result back to the host over a valid/ready handshake.
// Optional feature: define IOT_FEED_TIMEOUT_EN to bound the result wait to TIMEOUT_CYC cycles.
// On expiry the feeder returns a zero result with err_timeout set.

module iot_frame_feeder #(
    parameter int unsigned FRAME_BYTES = 16,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [8*FRAME_BYTES-1:0]   s_data,
    input  logic [2:0]                 s_fn,
    input  logic                       busy,
    output logic                       in_en,
    output logic [7:0]                 iot_in,
    output logic [2:0]                 fn_sel,
    input  logic                       valid,
    input  logic [8*FRAME_BYTES-1:0]   iot_out,
    output logic                       r_valid,
    input  logic                       r_ready,
    output logic [8*FRAME_BYTES-1:0]   r_data,
    output logic [2:0]                 r_fn,
    output logic                       err_timeout
);

    localparam int unsigned FrameW = 8 * FRAME_BYTES;
    localparam int unsigned CntW   = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [CntW-1:0] LastByte = CntW'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {StIdle, StSend, StWait, StHold} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [FrameW-1:0]   shift_q, shift_d;
    logic [2:0]          fn_q, fn_d;
    logic [FrameW-1:0]   r_data_q, r_data_d;
    logic [2:0]          r_fn_q, r_fn_d;
    logic                r_valid_q, r_valid_d;

`ifdef IOT_FEED_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYC - 1);

    logic [ToW-1:0]      to_cnt_q, to_cnt_d;
    logic                err_q, err_d;

    assign err_timeout = err_q;
`else
    // Without the timeout feature the wait is unbounded and the error flag never fires.
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign err_timeout = 1'b0;
`endif

    // A byte goes out on every SEND cycle the filter is not busy; busy always wins.
    assign in_en   = (state_q == StSend) && !busy;
    assign iot_in  = in_en ? shift_q[FrameW-1 -: 8] : 8'h00;
    assign fn_sel  = fn_q;
    assign s_ready = (state_q == StIdle);
    assign r_valid = r_valid_q;
    assign r_data  = r_data_q;
    assign r_fn    = r_fn_q;

    // Next-state logic for the frame FSM and its datapath registers.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        fn_d       = fn_q;
        r_data_d   = r_data_q;
        r_fn_d     = r_fn_q;
        r_valid_d  = r_valid_q;
`ifdef IOT_FEED_TIMEOUT_EN
        err_d      = err_q;
        // Counter only runs inside WAIT, so it is clear on every entry.
        to_cnt_d   = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (s_valid) begin
                    shift_d    = s_data;
                    fn_d       = s_fn;
                    byte_cnt_d = '0;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (in_en) begin
                    shift_d    = shift_q << 8;
                    byte_cnt_d = byte_cnt_q + CntW'(1);
                    if (byte_cnt_q == LastByte) begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (valid) begin
                    r_data_d  = iot_out;
                    r_fn_d    = fn_q;
                    r_valid_d = 1'b1;
                    state_d   = StHold;
`ifdef IOT_FEED_TIMEOUT_EN
                    err_d     = 1'b0;
                end else if (to_cnt_q == ToLast) begin
                    r_data_d  = '0;
                    r_fn_d    = fn_q;
                    r_valid_d = 1'b1;
                    err_d     = 1'b1;
                    state_d   = StHold;
                end else begin
                    to_cnt_d  = to_cnt_q + ToW'(1);
`endif
                end
            end
            StHold: begin
                if (r_ready) begin
                    r_valid_d = 1'b0;
`ifdef IOT_FEED_TIMEOUT_EN
                    err_d     = 1'b0;
`endif
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            fn_q       <= '0;
            r_data_q   <= '0;
            r_fn_q     <= '0;
            r_valid_q  <= 1'b0;
`ifdef IOT_FEED_TIMEOUT_EN
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            fn_q       <= fn_d;
            r_data_q   <= r_data_d;
            r_fn_q     <= r_fn_d;
            r_valid_q  <= r_valid_d;
`ifdef IOT_FEED_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_iot_frame_feeder.sv
// Directed bench for iot_frame_feeder: serialization order, busy stalls, stray result strobes,
// host backpressure, mid-frame reset and the result-wait behaviour (timeout when enabled).

module tb_iot_frame_feeder;

    localparam logic [127:0] FrameA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] FrameB = 128'hA5A5_0F0F_1122_3344_5566_7788_99AA_BBCC;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic [2:0]   s_fn;
    logic         busy;
    logic         in_en;
    logic [7:0]   iot_in;
    logic [2:0]   fn_sel;
    logic         valid;
    logic [127:0] iot_out;
    logic         r_valid;
    logic         r_ready;
    logic [127:0] r_data;
    logic [2:0]   r_fn;
    logic         err_timeout;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    iot_frame_feeder #(
        .FRAME_BYTES(16),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_fn       (s_fn),
        .busy       (busy),
        .in_en      (in_en),
        .iot_in     (iot_in),
        .fn_sel     (fn_sel),
        .valid      (valid),
        .iot_out    (iot_out),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_data     (r_data),
        .r_fn       (r_fn),
        .err_timeout(err_timeout)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offers one frame, then drives the SEND phase checking every cycle. A stall of stall_len
    // cycles is applied once stall_after bytes have gone; a stray valid is pulsed while byte
    // spur_at is due; abort_after > 0 leaves the loop once that many bytes have gone.
    task automatic run_frame(input logic [127:0] data, input logic [2:0] fn,
                             input int stall_after, input int stall_len, input int spur_at,
                             input int abort_after, output int strobes,
                             output logic [7:0] post_stall_byte);
        int k = 0;
        int stalled = 0;
        int cyc = 0;
        logic exp_en;
        logic [7:0] exp_byte;
        strobes = 0;
        post_stall_byte = 8'h00;
        s_data = data;
        s_fn = fn;
        s_valid = 1'b1;
        #1;
        vec_cnt++;
        if (s_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL accept_s_ready: got %b want 1", s_ready);
        end
        tick();
        s_valid = 1'b0;
        s_data = '0;
        while (k < 16 && cyc < 100) begin
            if (abort_after > 0 && k == abort_after) break;
            busy = (stall_len > 0 && k == stall_after && stalled < stall_len);
            valid = (k == spur_at);
            iot_out = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
            exp_en = !busy;
            exp_byte = exp_en ? data[127 - 8*k -: 8] : 8'h00;
            #1;
            vec_cnt++;
            if (in_en !== exp_en || iot_in !== exp_byte || fn_sel !== fn ||
                s_ready !== 1'b0 || r_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL send_byte%0d: got en=%b byte=%h fn=%0d s_ready=%b r_valid=%b want en=%b byte=%h fn=%0d s_ready=0 r_valid=0",
                         k, in_en, iot_in, fn_sel, s_ready, r_valid, exp_en, exp_byte, fn);
            end
            if (in_en === 1'b1) begin
                strobes++;
                if (stall_len > 0 && k == stall_after) post_stall_byte = iot_in;
            end
            if (busy) stalled++;
            else k++;
            cyc++;
            tick();
        end
        busy = 1'b0;
        valid = 1'b0;
        if (cyc >= 100) begin
            err_cnt++;
            $display("FAIL send_budget: got %0d cycles want < 100", cyc);
        end
    endtask

    // In WAIT: check quiet outputs for idle_wait cycles, then strobe the result in.
    task automatic wait_result(input logic [2:0] fn, input logic [127:0] res, input int idle_wait);
        for (int i = 0; i < idle_wait; i++) begin
            #1;
            vec_cnt++;
            if (r_valid !== 1'b0 || in_en !== 1'b0 || s_ready !== 1'b0) begin
                err_cnt++;
                $display("FAIL wait_quiet: got r_valid=%b in_en=%b s_ready=%b want 0 0 0",
                         r_valid, in_en, s_ready);
            end
            tick();
        end
        valid = 1'b1;
        iot_out = res;
        tick();
        valid = 1'b0;
        iot_out = '0;
        #1;
        vec_cnt++;
        if (r_valid !== 1'b1 || r_data !== res || r_fn !== fn || err_timeout !== 1'b0) begin
            err_cnt++;
            $display("FAIL capture: got r_valid=%b r_data=%h r_fn=%0d err=%b want 1 %h %0d 0",
                     r_valid, r_data, r_fn, err_timeout, res, fn);
        end
    endtask

    // In HOLD: keep r_ready low for hold cycles, then accept and check return to IDLE.
    task automatic release_result(input logic [2:0] fn, input logic [127:0] res,
                                  input logic exp_err, input int hold);
        for (int i = 0; i < hold; i++) begin
            #1;
            vec_cnt++;
            if (r_valid !== 1'b1 || r_data !== res || r_fn !== fn || s_ready !== 1'b0 ||
                err_timeout !== exp_err) begin
                err_cnt++;
                $display("FAIL hold_stable: got r_valid=%b r_data=%h r_fn=%0d s_ready=%b err=%b want 1 %h %0d 0 %b",
                         r_valid, r_data, r_fn, s_ready, err_timeout, res, fn, exp_err);
            end
            tick();
        end
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        #1;
        vec_cnt++;
        if (r_valid !== 1'b0 || s_ready !== 1'b1 || err_timeout !== 1'b0) begin
            err_cnt++;
            $display("FAIL release: got r_valid=%b s_ready=%b err=%b want 0 1 0",
                     r_valid, s_ready, err_timeout);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        s_valid = 1'b0; s_data = '0; s_fn = '0; busy = 1'b0;
        valid = 1'b0; iot_out = '0; r_ready = 1'b0;
        tick();
        tick();
        vec_cnt++;
        if (s_ready !== 1'b1 || in_en !== 1'b0 || iot_in !== 8'h00 || fn_sel !== 3'd0 ||
            r_valid !== 1'b0 || r_data !== '0 || r_fn !== 3'd0 || err_timeout !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_state: got s_ready=%b in_en=%b iot_in=%h fn_sel=%0d r_valid=%b r_data=%h r_fn=%0d err=%b want 1 0 00 0 0 0 0 0",
                     s_ready, in_en, iot_in, fn_sel, r_valid, r_data, r_fn, err_timeout);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int n;
        logic [7:0] pb;
        run_frame(FrameA, 3'd3, -1, 0, -1, 0, n, pb);
        vec_cnt++;
        if (n !== 16) begin
            err_cnt++;
            $display("FAIL basic_strobes: got %0d want 16", n);
        end
        wait_result(3'd3, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 2);
        release_result(3'd3, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, 1);
    endtask

    task automatic test_busy_stall;
        int n;
        logic [7:0] pb;
        run_frame(FrameA, 3'd5, 5, 3, -1, 0, n, pb);
        vec_cnt++;
        if (n !== 16 || pb !== 8'hAB) begin
            err_cnt++;
            $display("FAIL stall_resume: got strobes=%0d byte6=%h want 16 ab", n, pb);
        end
        wait_result(3'd5, 128'h0000_0000_0000_0000_0000_0000_0000_00C5, 1);
        release_result(3'd5, 128'h0000_0000_0000_0000_0000_0000_0000_00C5, 1'b0, 0);
    endtask

    task automatic test_spurious_valid;
        int n;
        logic [7:0] pb;
        valid = 1'b1;
        iot_out = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
        tick();
        valid = 1'b0;
        iot_out = '0;
        #1;
        vec_cnt++;
        if (r_valid !== 1'b0 || s_ready !== 1'b1 ||
            r_data !== 128'h0000_0000_0000_0000_0000_0000_0000_00C5) begin
            err_cnt++;
            $display("FAIL idle_valid: got r_valid=%b s_ready=%b r_data=%h want 0 1 c5",
                     r_valid, s_ready, r_data);
        end
        run_frame(FrameB, 3'd6, -1, 0, 4, 0, n, pb);
        vec_cnt++;
        if (n !== 16 || r_data !== 128'h0000_0000_0000_0000_0000_0000_0000_00C5) begin
            err_cnt++;
            $display("FAIL send_valid: got strobes=%0d r_data=%h want 16 c5", n, r_data);
        end
        wait_result(3'd6, 128'h6666_0000_0000_0000_0000_0000_0000_0006, 3);
        release_result(3'd6, 128'h6666_0000_0000_0000_0000_0000_0000_0006, 1'b0, 0);
    endtask

    task automatic test_hold_backpressure;
        int n;
        logic [7:0] pb;
        run_frame(FrameB, 3'd7, -1, 0, -1, 0, n, pb);
        wait_result(3'd7, 128'h7777_7777_0000_0000_1234_5678_0000_0007, 0);
        release_result(3'd7, 128'h7777_7777_0000_0000_1234_5678_0000_0007, 1'b0, 10);
    endtask

    task automatic test_reset_midframe;
        int n;
        logic [7:0] pb;
        run_frame(FrameB, 3'd1, -1, 0, -1, 7, n, pb);
        vec_cnt++;
        if (n !== 7) begin
            err_cnt++;
            $display("FAIL abort_strobes: got %0d want 7", n);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        vec_cnt++;
        if (in_en !== 1'b0 || s_ready !== 1'b1 || r_valid !== 1'b0 || iot_in !== 8'h00) begin
            err_cnt++;
            $display("FAIL midframe_reset: got in_en=%b s_ready=%b r_valid=%b iot_in=%h want 0 1 0 00",
                     in_en, s_ready, r_valid, iot_in);
        end
        run_frame(FrameA, 3'd2, -1, 0, -1, 0, n, pb);
        vec_cnt++;
        if (n !== 16) begin
            err_cnt++;
            $display("FAIL restart_strobes: got %0d want 16", n);
        end
        wait_result(3'd2, 128'h2222_0000_0000_0000_0000_0000_0000_2222, 1);
        release_result(3'd2, 128'h2222_0000_0000_0000_0000_0000_0000_2222, 1'b0, 0);
    endtask

`ifdef IOT_FEED_TIMEOUT_EN
    task automatic test_wait;
        int n;
        logic [7:0] pb;
        run_frame(FrameA, 3'd4, -1, 0, -1, 0, n, pb);
        for (int i = 0; i < 8; i++) begin
            #1;
            vec_cnt++;
            if (r_valid !== 1'b0 || err_timeout !== 1'b0) begin
                err_cnt++;
                $display("FAIL timeout_early%0d: got r_valid=%b err=%b want 0 0",
                         i, r_valid, err_timeout);
            end
            tick();
        end
        #1;
        vec_cnt++;
        if (r_valid !== 1'b1 || err_timeout !== 1'b1 || r_data !== '0 || r_fn !== 3'd4) begin
            err_cnt++;
            $display("FAIL timeout_fire: got r_valid=%b err=%b r_data=%h r_fn=%0d want 1 1 0 4",
                     r_valid, err_timeout, r_data, r_fn);
        end
        release_result(3'd4, '0, 1'b1, 3);
    endtask
`else
    task automatic test_wait;
        int n;
        logic [7:0] pb;
        run_frame(FrameA, 3'd4, -1, 0, -1, 0, n, pb);
        wait_result(3'd4, 128'h4444_4444_4444_4444_4444_4444_4444_4444, 20);
        release_result(3'd4, 128'h4444_4444_4444_4444_4444_4444_4444_4444, 1'b0, 0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_busy_stall();
        test_spurious_valid();
        test_hold_backpressure();
        test_reset_midframe();
        test_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
